// File: rtl/sma_pulse_gen.sv
// sma_pulse_gen: Avalon-MM slave pulse/burst generator for the SMA output pin.
// A rising edge on trigger_in (when TRIG_EN is set) or a software START fires a
// burst of PULSE_COUNT pulses; each pulse is HIGH_TICKS active followed by
// LOW_TICKS gap. PULSE_COUNT = 0 runs continuously until STOP.
// Optional feature: define SMA_PULSE_IRQ_EN to enable the masked done interrupt.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address, chipselect,  Avalon-MM slave; readdata is combinational
//   write_n, writedata,
//   readdata
//   trigger_in            start request from the SMA output PIO
//   sma_pulse             registered pulse output
//   irq                   registered DONE & IRQ_MASK (0 without SMA_PULSE_IRQ_EN)
module sma_pulse_gen #(
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        trigger_in,
  output logic        sma_pulse,
  output logic        irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GAP} state_e;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_HIGH  = 2'd1;
  localparam logic [1:0] ADDR_LOW   = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   high_ticks_q, low_ticks_q, pulse_count_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               trig_en_q, idle_level_q, idle_level_d;
  logic               done_q, done_d;
  logic               trig_d_q;
  logic               sma_q, sma_d;
  logic               irq_mask_q;

  logic               wr_en, ctrl_wr, start_wr, stop_wr, done_clr;
  logic               trig_edge, phase_end;
  logic [CNT_W-1:0]   high_load, low_load;
  logic               unused_wdata;

  // Bus decode
  assign wr_en    = chipselect & ~write_n;
  assign ctrl_wr  = wr_en & (address == ADDR_CTRL);
  assign start_wr = ctrl_wr & writedata[0];
  assign stop_wr  = ctrl_wr & writedata[1];
  assign done_clr = ctrl_wr & writedata[4];
  assign unused_wdata = ^writedata;

  assign trig_edge = trigger_in & ~trig_d_q & trig_en_q;
  // Counter is always loaded with at least 1, so it never sits at 0 while busy
  assign phase_end = (cnt_q == CNT_W'(1));
  assign high_load = (high_ticks_q == '0) ? CNT_W'(1) : high_ticks_q;
  assign low_load  = (low_ticks_q  == '0) ? CNT_W'(1) : low_ticks_q;

  // New idle level is visible on the output right after the write edge
  assign idle_level_d = ctrl_wr ? writedata[3] : idle_level_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; STOP overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_wr || trig_edge) state_d = ST_ACTIVE;
      ST_ACTIVE: if (phase_end) state_d = ST_GAP;
      ST_GAP:    if (phase_end) state_d = (rem_q != CNT_W'(1)) ? ST_ACTIVE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (stop_wr) state_d = ST_IDLE;
  end

  // Counter, done and output next values
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    done_d = done_q & ~done_clr;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_ACTIVE) begin
          cnt_d = high_load;
          rem_d = pulse_count_q;
        end
      end
      ST_ACTIVE: begin
        if (state_d == ST_GAP)    cnt_d = low_load;
        else                      cnt_d = cnt_q - CNT_W'(1);
      end
      ST_GAP: begin
        if (state_d == ST_ACTIVE) begin
          cnt_d = high_load;
          // rem of 0 marks a continuous burst and is never decremented
          if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
        end else if (state_d == ST_GAP) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!stop_wr) begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
    sma_d = (state_d == ST_ACTIVE) ? ~idle_level_d : idle_level_d;
  end

  // Datapath and register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_ticks_q  <= CNT_W'(1);
      low_ticks_q   <= CNT_W'(1);
      pulse_count_q <= CNT_W'(1);
      trig_en_q     <= 1'b0;
      idle_level_q  <= 1'b0;
      done_q        <= 1'b0;
      trig_d_q      <= 1'b0;
      cnt_q         <= '0;
      rem_q         <= '0;
      sma_q         <= 1'b0;
    end else begin
      if (ctrl_wr) trig_en_q <= writedata[2];
      if (wr_en && address == ADDR_HIGH)  high_ticks_q  <= writedata[CNT_W-1:0];
      if (wr_en && address == ADDR_LOW)   low_ticks_q   <= writedata[CNT_W-1:0];
      if (wr_en && address == ADDR_COUNT) pulse_count_q <= writedata[CNT_W-1:0];
      idle_level_q <= idle_level_d;
      done_q       <= done_d;
      trig_d_q     <= trigger_in;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      sma_q        <= sma_d;
    end
  end

  assign sma_pulse = sma_q;

`ifdef SMA_PULSE_IRQ_EN
  logic irq_q;

  // Interrupt follows DONE one cycle later when unmasked
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (ctrl_wr) irq_mask_q <= writedata[5];
      irq_q <= done_q & irq_mask_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq_mask_q = 1'b0;
  assign irq        = 1'b0;
`endif

  // Combinational read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:  readdata = {26'd0, irq_mask_q, done_q, idle_level_q, trig_en_q,
                              1'b0, (state_q != ST_IDLE)};
      ADDR_HIGH:  readdata = 32'(high_ticks_q);
      ADDR_LOW:   readdata = 32'(low_ticks_q);
      ADDR_COUNT: readdata = 32'(pulse_count_q);
      default:    readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sma_pulse_gen.sv
// tb_sma_pulse_gen: directed self-checking bench for sma_pulse_gen.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sma_pulse_gen;

  logic        clk, reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, readdata;
  logic        trigger_in, sma_pulse, irq;

  int checks = 0;
  int errors = 0;

`ifdef SMA_PULSE_IRQ_EN
  localparam logic [31:0] MSK     = 32'h20;
  localparam logic [31:0] IRQ_EXP = 32'h1;
`else
  localparam logic [31:0] MSK     = 32'h0;
  localparam logic [31:0] IRQ_EXP = 32'h0;
`endif

  sma_pulse_gen #(.CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .trigger_in (trigger_in),
    .sma_pulse  (sma_pulse),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge (cycle 1 after the write)
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic sma_chk(input string tag, input logic exp);
    check(tag, 32'(sma_pulse), 32'(exp));
  endtask

  initial begin
    logic [9:0] pat;
    int hc;

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; trigger_in = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    rd_chk("rst_ctrl", 2'd0, 32'h0);
    rd_chk("rst_high", 2'd1, 32'h1);
    rd_chk("rst_low",  2'd2, 32'h1);
    rd_chk("rst_cnt",  2'd3, 32'h1);
    sma_chk("rst_sma", 1'b0);
    check("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single burst HIGH=3 LOW=2 COUNT=2
    wr(2'd1, 32'd3); wr(2'd2, 32'd2); wr(2'd3, 32'd2);
    rd_chk("rb_high", 2'd1, 32'd3);
    wr(2'd0, 32'h1);
    rd_chk("burst_busy", 2'd0, 32'h1);
    pat = 10'b0011100111;  // bit k-1 = expected level in cycle k
    for (int k = 1; k <= 10; k++) begin
      sma_chk($sformatf("burst_c%0d", k), pat[k-1]);
      @(negedge clk);
    end
    rd_chk("burst_done", 2'd0, 32'h10);
    wr(2'd0, 32'h10);
    rd_chk("done_clr", 2'd0, 32'h0);

    // Trigger start, held high 5 cycles -> one 1-cycle pulse
    wr(2'd1, 32'd1); wr(2'd2, 32'd1); wr(2'd3, 32'd1);
    wr(2'd0, 32'h4);
    hc = 0;
    trigger_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) sma_chk("trig_first", 1'b1);
      hc += int'(sma_pulse);
      trigger_in = (i < 4);
    end
    check("trig_hold_count", 32'(hc), 32'd1);

    // Second edge during the gap is ignored
    wr(2'd2, 32'd4);
    hc = 0;
    for (int i = 0; i < 12; i++) begin
      trigger_in = (i == 0 || i == 2);
      @(negedge clk);
      hc += int'(sma_pulse);
    end
    check("trig_busy_count", 32'(hc), 32'd1);

    // TRIG_EN=0 -> no pulse
    wr(2'd0, 32'h0);
    hc = 0;
    for (int i = 0; i < 6; i++) begin
      trigger_in = (i < 2);
      @(negedge clk);
      hc += int'(sma_pulse);
    end
    check("trig_dis_count", 32'(hc), 32'd0);

    // Continuous + STOP
    wr(2'd0, 32'h10);
    wr(2'd1, 32'd2); wr(2'd2, 32'd2); wr(2'd3, 32'd0);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 11; k++) begin
      sma_chk($sformatf("cont_c%0d", k), ((k - 1) % 4) < 2);
      if (k < 11) @(negedge clk);
    end
    wr(2'd0, 32'h2);
    for (int k = 12; k <= 15; k++) begin
      sma_chk($sformatf("stop_c%0d", k), 1'b0);
      @(negedge clk);
    end
    rd_chk("stop_ctrl", 2'd0, 32'h0);

    // Polarity and zero tick values
    wr(2'd1, 32'd0); wr(2'd2, 32'd0); wr(2'd3, 32'd1);
    rd_chk("rb_high0", 2'd1, 32'd0);
    wr(2'd0, 32'h8);
    sma_chk("idle_hi", 1'b1);
    wr(2'd0, 32'hB);
    sma_chk("startstop_sma", 1'b1);
    rd_chk("startstop_ctrl", 2'd0, 32'h8);
    wr(2'd0, 32'h9);
    sma_chk("pol_c1", 1'b0);
    @(negedge clk);
    sma_chk("pol_c2", 1'b1);
    rd_chk("pol_c2_busy", 2'd0, 32'h9);
    @(negedge clk);
    sma_chk("pol_c3", 1'b1);
    rd_chk("pol_done", 2'd0, 32'h18);

    // IRQ
    wr(2'd0, 32'h30);
    wr(2'd1, 32'd1); wr(2'd2, 32'd1); wr(2'd3, 32'd1);
    wr(2'd0, 32'h21);
    sma_chk("irq_c1", 1'b1);
    @(negedge clk);
    @(negedge clk);
    rd_chk("irq_c3_ctrl", 2'd0, 32'h10 | MSK);
    check("irq_c3", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_c4", 32'(irq), IRQ_EXP);
    wr(2'd0, 32'h30);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'h0);
    rd_chk("irq_clr_ctrl", 2'd0, MSK);

    // Reset mid-burst
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);
    sma_chk("mid_c1", 1'b1);
    #2 reset_n = 1'b0;
    #1;
    sma_chk("mid_rst_sma", 1'b0);
    rd_chk("mid_rst_ctrl", 2'd0, 32'h0);
    rd_chk("mid_rst_high", 2'd1, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sma_chk("post_rst_sma", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
